// File: rtl/roce_tx_payload_gen.sv
// Emits ceil(len/8) pattern beats {~byte_cnt, byte_cnt} per start edge; tvalid rises the cycle after the start edge.
// Backpressure: outputs are register-driven and held while tready is low; one beat per cycle when tready stays high.
module roce_tx_payload_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           dma_transfer_length,
    input  logic                  start_transfer,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic                  start_ignored,
    output logic [31:0]           beat_count
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state, state_nxt;
    logic        start_prev;
    logic        start_edge;
    logic        hs;
    logic [31:0] byte_cnt;
    logic [31:0] len_reg;
    logic [32:0] end_sum;
    logic [3:0]  rem_lo;
    logic [7:0]  keep_last;

    assign start_edge    = start_transfer & ~start_prev;
    assign m_axis_tvalid = (state == SEND);
    assign busy          = (state == SEND);
    assign hs            = m_axis_tvalid & m_axis_tready;

    // 33-bit sum so lengths near 2^32 cannot wrap the last-beat test
    assign end_sum      = {1'b0, byte_cnt} + 33'd8;
    assign m_axis_tlast = (end_sum >= {1'b0, len_reg});

    // On the last beat 1..8 bytes remain, so the low nibble difference is exact
    assign rem_lo    = len_reg[3:0] - byte_cnt[3:0];
    assign keep_last = 8'hFF >> (4'd8 - rem_lo);

    assign m_axis_tkeep = m_axis_tlast ? keep_last : 8'hFF;
    assign m_axis_tdata = {~byte_cnt, byte_cnt};
    assign m_axis_tuser = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_edge && (dma_transfer_length != 32'd0)) state_nxt = SEND;
            SEND: if (hs && m_axis_tlast) state_nxt = IDLE;
        endcase
    end

    // start_prev resets high so a level held through reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev <= 1'b1;
        end else begin
            start_prev <= start_transfer;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt      <= 32'd0;
            len_reg       <= 32'd0;
            beat_count    <= 32'd0;
            done          <= 1'b0;
            start_ignored <= 1'b0;
        end else begin
            done          <= ((state == IDLE) && start_edge && (dma_transfer_length == 32'd0)) ||
                             (hs && m_axis_tlast);
            start_ignored <= (state == SEND) && start_edge;
            if ((state == IDLE) && start_edge) begin
                beat_count <= 32'd0;
                byte_cnt   <= 32'd0;
                if (dma_transfer_length != 32'd0) begin
                    len_reg <= dma_transfer_length;
                end
            end else if (hs) begin
                byte_cnt   <= byte_cnt + 32'd8;
                beat_count <= beat_count + 32'd1;
            end
        end
    end

endmodule
